// File: rtl/icache_responder_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction cache responder: the refill state
// machine encoding, default geometry, the address-field widths that follow
// from that geometry, and the instruction value driven while stalled.
// Modules that take their own LINES / WORDS_PER_LINE parameters derive
// their widths with the helper functions so that they stay consistent.
// ---------------------------------------------------------------------------
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam int DEFAULT_LINES          = 64;
    localparam int DEFAULT_WORDS_PER_LINE = 4;

    // Byte offset within a line (word select plus the two ignored byte bits)
    localparam int OFFSET_W = $clog2(DEFAULT_WORDS_PER_LINE) + 2;
    localparam int INDEX_W  = $clog2(DEFAULT_LINES);
    localparam int TAG_W    = 32 - OFFSET_W - INDEX_W;

    // Driven on the instruction output whenever the fetch cannot be serviced
    localparam logic [31:0] NOP_INST = 32'h0;

    function automatic int offsetWidth(input int wordsPerLine);
        return $clog2(wordsPerLine) + 2;
    endfunction

    function automatic int tagWidth(input int lines, input int wordsPerLine);
        return 32 - offsetWidth(wordsPerLine) - $clog2(lines);
    endfunction

endpackage

// File: rtl/icache_responder_if.sv
// ---------------------------------------------------------------------------
// icache_responder_if
// Bundles the fetch-side and memory-side signals of the instruction cache.
//   fetch : pc_in, pc_access_mem_valid, flush  -> cache
//           inst_out, I_cache_stall            <- cache
//   memory: mem_req, mem_addr                  <- cache
//           mem_ack, mem_rdata                 -> cache
//   stats : hit_count, miss_count              <- cache
// The slave modport is the cache; the master modport is everything around
// it (PC stage plus instruction memory).
// ---------------------------------------------------------------------------
interface icache_responder_if;

    logic [31:0] pc_in;
    logic        pc_access_mem_valid;
    logic        flush;
    logic [31:0] inst_out;
    logic        I_cache_stall;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport slave (
        input  pc_in, pc_access_mem_valid, flush, mem_ack, mem_rdata,
        output inst_out, I_cache_stall, mem_req, mem_addr, hit_count, miss_count
    );

    modport master (
        output pc_in, pc_access_mem_valid, flush, mem_ack, mem_rdata,
        input  inst_out, I_cache_stall, mem_req, mem_addr, hit_count, miss_count
    );

endinterface

// File: rtl/icache_responder_refill_fsm.sv
// ---------------------------------------------------------------------------
// icache_refill_fsm
// Refill controller: owns the IDLE/REFILL/COMMIT state, the beat counter,
// the memory request handshake, the latched miss line address and the
// pending-flush flag.
//   clk, rst         : clock, asynchronous active-low reset
//   i_missDetect     : lookup missed (only looked at in IDLE)
//   i_pcIn           : fetch address, latched as the miss line on a miss
//   i_flush          : flush pulse, remembered if it arrives mid-refill
//   i_memAck         : memory delivers the current beat
//   o_state, o_beat  : current state and beat index
//   o_memReq/Addr    : refill word request and its byte address
//   o_missIndex/Tag  : line being refilled
//   o_flushPending   : a flush arrived while refilling
// ---------------------------------------------------------------------------
import icache_pkg::*;

module icache_refill_fsm #(
    parameter int LINES          = DEFAULT_LINES,
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_missDetect,
    input  logic [31:0]                            i_pcIn,
    input  logic                                   i_flush,
    input  logic                                   i_memAck,
    output state_t                                 o_state,
    output logic [$clog2(WORDS_PER_LINE)-1:0]      o_beat,
    output logic                                   o_memReq,
    output logic [31:0]                            o_memAddr,
    output logic [$clog2(LINES)-1:0]               o_missIndex,
    output logic [tagWidth(LINES, WORDS_PER_LINE)-1:0] o_missTag,
    output logic                                   o_flushPending
);

    localparam int BEAT_W = $clog2(WORDS_PER_LINE);
    localparam int OFF_W  = offsetWidth(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TG_W   = tagWidth(LINES, WORDS_PER_LINE);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [31:0]       LINE_MASK = ~(32'(WORDS_PER_LINE * 4) - 32'd1);

    state_t            r_state;
    state_t            w_nextState;
    logic [BEAT_W-1:0] r_beat;
    logic [31:0]       r_missAddr;
    logic              r_flushPending;

    // State register; a reset mid-refill simply abandons the request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Miss address, beat counter and flush memory advance alongside the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_beat         <= '0;
            r_missAddr     <= 32'h0;
            r_flushPending <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_missDetect) begin
                        r_missAddr <= i_pcIn & LINE_MASK;
                        r_beat     <= '0;
                    end
                end
                REFILL: begin
                    if (i_flush) begin
                        r_flushPending <= 1'b1;
                    end
                    // Wraps to zero on the last beat, ready for the next miss
                    if (i_memAck) begin
                        r_beat <= r_beat + BEAT_ONE;
                    end
                end
                COMMIT: begin
                    r_flushPending <= 1'b0;
                end
                default: begin
                    r_flushPending <= 1'b0;
                end
            endcase
        end
    end

    // Next state plus the request outputs, held stable for the whole beat
    always_comb begin
        w_nextState = r_state;
        o_memReq    = 1'b0;
        o_memAddr   = 32'h0;
        case (r_state)
            IDLE: begin
                if (i_missDetect) begin
                    w_nextState = REFILL;
                end
            end
            REFILL: begin
                o_memReq  = 1'b1;
                o_memAddr = r_missAddr + 32'({r_beat, 2'b00});
                if (i_memAck && (r_beat == LAST_BEAT)) begin
                    w_nextState = COMMIT;
                end
            end
            COMMIT: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    assign o_state        = r_state;
    assign o_beat         = r_beat;
    assign o_missIndex    = r_missAddr[OFF_W +: IDX_W];
    assign o_missTag      = r_missAddr[31 -: TG_W];
    assign o_flushPending = r_flushPending;

endmodule

// File: rtl/icache_responder.sv
// ---------------------------------------------------------------------------
// icache_responder
// Direct-mapped, read-only instruction cache between the PC stage and the
// instruction memory. Hits return the word in the same cycle; misses refill
// the whole line over a req/ack handshake and then re-look-up the PC.
//   clk  : system clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : fetch, refill and statistics signals (slave side)
// ---------------------------------------------------------------------------
import icache_pkg::*;

module icache_responder #(
    parameter int LINES          = DEFAULT_LINES,
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE
) (
    input  logic                  clk,
    input  logic                  rst,
    icache_responder_if.slave     bus
);

    localparam int WSEL_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int TG_W   = tagWidth(LINES, WORDS_PER_LINE);

    logic [LINES-1:0]  r_valid;
    logic [TG_W-1:0]   r_tag     [LINES];
    logic [31:0]       r_data    [LINES][WORDS_PER_LINE];
    logic [31:0]       r_lineBuf [WORDS_PER_LINE];
    logic [31:0]       r_hitCount;
    logic [31:0]       r_missCount;

    logic [WSEL_W-1:0] w_wordSel;
    logic [IDX_W-1:0]  w_index;
    logic [TG_W-1:0]   w_tag;
    logic              w_hit;
    logic              w_stall;
    logic [31:0]       w_inst;
    logic              w_unusedByteBits;

    state_t            w_state;
    logic [WSEL_W-1:0] w_beat;
    logic [IDX_W-1:0]  w_missIndex;
    logic [TG_W-1:0]   w_missTag;
    logic              w_flushPending;

    assign w_wordSel        = bus.pc_in[2 +: WSEL_W];
    assign w_index          = bus.pc_in[2 + WSEL_W +: IDX_W];
    assign w_tag            = bus.pc_in[31 -: TG_W];
    assign w_unusedByteBits = ^bus.pc_in[1:0];
    assign w_hit            = r_valid[w_index] && (r_tag[w_index] == w_tag);

    icache_refill_fsm #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_refillFsm (
        .clk            (clk),
        .rst            (rst),
        .i_missDetect   (!w_hit),
        .i_pcIn         (bus.pc_in),
        .i_flush        (bus.flush),
        .i_memAck       (bus.mem_ack),
        .o_state        (w_state),
        .o_beat         (w_beat),
        .o_memReq       (bus.mem_req),
        .o_memAddr      (bus.mem_addr),
        .o_missIndex    (w_missIndex),
        .o_missTag      (w_missTag),
        .o_flushPending (w_flushPending)
    );

    // Fetch response: only an IDLE hit is serviceable. The stall is held low
    // while reset is asserted so the PC stage sees a quiet interface.
    always_comb begin
        w_stall = 1'b1;
        w_inst  = NOP_INST;
        if (!rst) begin
            w_stall = 1'b0;
        end else if ((w_state == IDLE) && w_hit) begin
            w_stall = 1'b0;
            w_inst  = r_data[w_index][w_wordSel];
        end
    end

    assign bus.I_cache_stall = w_stall;
    assign bus.inst_out      = w_inst;

    // Valid bits. A flush seen during refill (or during COMMIT itself) drops
    // every line, including the one being committed, so the fence is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if ((w_state == IDLE) && bus.flush) begin
            r_valid <= '0;
        end else if (w_state == COMMIT) begin
            if (w_flushPending || bus.flush) begin
                r_valid <= '0;
            end else begin
                r_valid[w_missIndex] <= 1'b1;
            end
        end
    end

    // Line buffer collects beats; COMMIT copies it and the tag into the array
    always_ff @(posedge clk) begin
        if ((w_state == REFILL) && bus.mem_ack) begin
            r_lineBuf[w_beat] <= bus.mem_rdata;
        end
        if (w_state == COMMIT) begin
            r_tag[w_missIndex] <= w_missTag;
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                r_data[w_missIndex][w] <= r_lineBuf[w];
            end
        end
    end

    // Statistics only count qualified fetches; misses count when the refill starts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hitCount  <= 32'h0;
            r_missCount <= 32'h0;
        end else if ((w_state == IDLE) && bus.pc_access_mem_valid) begin
            if (w_hit) begin
                r_hitCount <= r_hitCount + 32'd1;
            end else begin
                r_missCount <= r_missCount + 32'd1;
            end
        end
    end

    assign bus.hit_count  = r_hitCount;
    assign bus.miss_count = r_missCount;

endmodule
